// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped read-only instruction cache with line refill and index invalidate
module icache_ctrl #(
    parameter int IDX_BITS = 7,
    parameter int OFS_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        stb,
    output logic [31:0] inst,
    output logic        stall,
    input  logic        inv,
    input  logic [31:0] inv_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int LINE_LSB = 2 + OFS_BITS;
    localparam int TAG_LSB  = LINE_LSB + IDX_BITS;
    localparam int TAG_BITS = 32 - TAG_LSB;
    localparam int LINES    = 1 << IDX_BITS;
    localparam int WORDS    = LINES << OFS_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_FILLED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OFS_BITS-1:0]    cnt_q, cnt_d;
    logic [31-LINE_LSB:0]   line_q, line_d;
    logic                   mem_req_q, mem_req_d;
    logic [LINES-1:0]       valid_q, valid_d;

    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [WORDS];

    logic                   data_we;
    logic                   tag_we;
    logic                   hit;

    logic [TAG_BITS-1:0]    fetch_tag;
    logic [IDX_BITS-1:0]    fetch_idx;
    logic [OFS_BITS-1:0]    fetch_word;
    logic [IDX_BITS-1:0]    inv_idx;
    logic [IDX_BITS-1:0]    fill_idx;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   unused_bits;

    assign fetch_tag  = addr[31:TAG_LSB];
    assign fetch_idx  = addr[TAG_LSB-1:LINE_LSB];
    assign fetch_word = addr[LINE_LSB-1:2];
    assign inv_idx    = inv_addr[TAG_LSB-1:LINE_LSB];
    assign fill_idx   = line_q[IDX_BITS-1:0];
    assign fill_tag   = line_q[31-LINE_LSB:IDX_BITS];

    // Byte offset and the non-index bits of inv_addr carry no information here.
    assign unused_bits = ^{addr[1:0], inv_addr[31:TAG_LSB], inv_addr[LINE_LSB-1:0]};

    assign hit      = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign inst     = data_mem[{fetch_idx, fetch_word}];
    assign mem_req  = mem_req_q;
    assign mem_addr = {line_q, {LINE_LSB{1'b0}}};

    // Next-state, stall and array write enables; invalidate is applied last so it wins a same-cycle valid set.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        mem_req_d = mem_req_q;
        valid_d   = valid_q;
        stall     = 1'b1;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = stb & ~hit;
                if (stb && !hit) begin
                    line_d    = addr[31:LINE_LSB];
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_valid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == {OFS_BITS{1'b1}}) begin
                        tag_we            = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        mem_req_d         = 1'b0;
                        state_d           = S_FILLED;
                    end
                end
            end
            S_FILLED: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        if (inv) begin
            valid_d[inv_idx] = 1'b0;
        end
    end

    // Control registers; reset drops any refill in flight and invalidates every line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            mem_req_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            mem_req_q <= mem_req_d;
            valid_q   <= valid_d;
        end
    end

    // Tag and data arrays; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && data_we) begin
            data_mem[{fill_idx, cnt_q}] <= mem_data;
        end
        if (!rst && tag_we) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

endmodule
